sub: RTL and testbench
======================

SUB -- requirements
Module: sub

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; only 32 is required to be supported.
REQ-002 clock  input  1  single clock; rising edge used only by the sticky-overflow register.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 data_result  output  32  A minus B, two's complement, modulo 2^32.
REQ-005 data_operandA  input  32  minuend A.
REQ-006 data_operandB  input  32  subtrahend B.
REQ-007 overflow  output  1  signed overflow of the current subtraction, combinational.
REQ-008 ovf_sticky  output  1  registered flag, set by any overflow sampled at a clock edge.
REQ-009 Port order SHALL be as listed; integrators SHALL connect ports by name.

Function
REQ-010 data_result SHALL equal (A + ~B + 1) mod 2^32, computed combinationally with zero clock latency.
REQ-011 data_result and overflow SHALL settle within 1 ns of any operand change; no clock edge is required.
REQ-012 overflow SHALL be 1 exactly when A[31] != B[31] and data_result[31] != A[31]; otherwise 0.
REQ-013 Unsigned borrow SHALL NOT be reported; 0 - 1 gives 0xFFFFFFFF with overflow=0.
REQ-014 Results SHALL wrap modulo 2^32 for all operand combinations, with no saturation.
REQ-015 The adder SHALL be carry-lookahead: four 8-bit lookahead blocks plus a second-level lookahead across the block generate/propagate signals; a ripple chain across all 32 bits is forbidden.
REQ-016 ovf_sticky SHALL load (ovf_sticky | overflow) on each rising clock edge.
REQ-017 ovf_sticky SHALL otherwise hold its value and SHALL never clear itself.
REQ-018 If overflow pulses between clock edges, ovf_sticky SHALL NOT capture the pulse.
REQ-019 If reset_n is asserted on the same edge that overflow=1, reset SHALL win and ovf_sticky SHALL read 0.

Reset
REQ-020 Asserting reset_n=0 SHALL immediately clear ovf_sticky to 0, independent of clock.
REQ-021 Reset SHALL NOT affect data_result or overflow; these stay purely combinational during reset.
REQ-022 After reset_n deasserts, the first capture SHALL occur at the next rising clock edge.

Structure
REQ-023 A shared package SHALL hold the constants DATA_W=32 and BLOCK_W=8.
REQ-024 One sub-module SHALL be used: cla_8, an 8-bit lookahead block.
  - Inputs: a, b, cin.
  - Outputs: sum, block generate G, block propagate P.
REQ-025 sub SHALL instantiate four cla_8 blocks, the inversion of B, the carry-in of 1, the top-level lookahead logic, overflow detection and the sticky flop.

Verification
REQ-026 A=162346, B=24124 -> data_result=138222, overflow=0; then toggle A[0], A[1], B[0], A[7], B[7] every 10/20/40 ns -> each display 1 ns after a change equals A-B exactly.
REQ-027 A=0x7FFFFFFF, B=0xFFFFFFFF -> data_result=0x80000000, overflow=1.
REQ-028 A=0x80000000, B=1 -> data_result=0x7FFFFFFF, overflow=1; A=5, B=5 -> data_result=0, overflow=0.
REQ-029 A=0, B=1 -> data_result=0xFFFFFFFF, overflow=0; A=0x80000000, B=0x80000000 -> data_result=0, overflow=0.
REQ-030 Sticky-flag sequence:
  - Clock with overflow=1 -> ovf_sticky=1.
  - Change to non-overflow operands for 3 clocks -> ovf_sticky stays 1.
  - Pull reset_n low mid-cycle -> ovf_sticky=0 immediately.
REQ-031 Random sweep of 10,000 operand pairs -> data_result and overflow match the reference model above.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants and helpers for the carry-lookahead subtractor.
// The lookahead helper folds generate/propagate terms over the low n bits of a group.
package sub_pkg;

  localparam int DATA_W  = 32;
  localparam int BLOCK_W = 8;
  localparam int NUM_BLK = DATA_W / BLOCK_W;

  // Returns {group_generate, group_propagate} for bits [n-1:0]; loop bound is fixed.
  function automatic logic [1:0] group_gp(input logic [BLOCK_W-1:0] g,
                                          input logic [BLOCK_W-1:0] p,
                                          input int                 n);
    logic gen_acc;
    logic prop_acc;
    gen_acc  = 1'b0;
    prop_acc = 1'b1;
    for (int j = BLOCK_W - 1; j >= 0; j--) begin
      if (j < n) begin
        gen_acc  = gen_acc | (prop_acc & g[j]);
        prop_acc = prop_acc & p[j];
      end
    end
    return {gen_acc, prop_acc};
  endfunction

  // Signed overflow of a - b, given the sign bits of a, b and the result.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub_cla_8.sv
// 8-bit carry-lookahead block: every internal carry is a flat sum of products,
// and the block exports its group generate/propagate for the second level.
module cla_8
  import sub_pkg::*;
(
  input  logic [BLOCK_W-1:0] a,
  input  logic [BLOCK_W-1:0] b,
  input  logic               cin,
  output logic [BLOCK_W-1:0] sum,
  output logic               G,
  output logic               P
);

  logic [BLOCK_W-1:0] g;
  logic [BLOCK_W-1:0] p;
  logic [BLOCK_W-1:0] carry;

  assign g = a & b;
  assign p = a ^ b;

  // G/P kept separate from the carry logic so they never depend on cin.
  assign {G, P} = group_gp(g, p, BLOCK_W);

  always_comb begin
    logic [1:0] gp;
    gp       = 2'b00;
    carry    = '0;
    carry[0] = cin;
    for (int i = 1; i < BLOCK_W; i++) begin
      gp       = group_gp(g, p, i);
      carry[i] = gp[1] | (gp[0] & cin);
    end
  end

  assign sum = p ^ carry;

endmodule

// File: rtl/sub.sv
// 32-bit subtractor A - B built as A + ~B + 1 on a two-level carry-lookahead adder,
// with combinational signed overflow and a sticky overflow flag.
module sub
  import sub_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [WIDTH-1:0] data_result,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             overflow,
  output logic             ovf_sticky
);

  localparam logic CARRY_IN = 1'b1;

  logic [DATA_W-1:0]  b_inv;
  logic [NUM_BLK-1:0] blk_g;
  logic [NUM_BLK-1:0] blk_p;
  logic [NUM_BLK:0]   blk_c;
  logic               unused_carry_out;

  assign b_inv = ~data_operandB;

  // Second-level lookahead across the block generate/propagate signals.
  always_comb begin
    logic [1:0] gp;
    gp       = 2'b00;
    blk_c    = '0;
    blk_c[0] = CARRY_IN;
    for (int i = 1; i <= NUM_BLK; i++) begin
      gp       = group_gp({{(BLOCK_W - NUM_BLK){1'b0}}, blk_g},
                          {{(BLOCK_W - NUM_BLK){1'b0}}, blk_p}, i);
      blk_c[i] = gp[1] | (gp[0] & CARRY_IN);
    end
  end

  // The unsigned carry-out (no-borrow) is deliberately not reported.
  assign unused_carry_out = blk_c[NUM_BLK];

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
    cla_8 u_cla (
      .a   (data_operandA[k*BLOCK_W +: BLOCK_W]),
      .b   (b_inv[k*BLOCK_W +: BLOCK_W]),
      .cin (blk_c[k]),
      .sum (data_result[k*BLOCK_W +: BLOCK_W]),
      .G   (blk_g[k]),
      .P   (blk_p[k])
    );
  end

  assign overflow = signed_ovf(data_operandA[DATA_W-1], data_operandB[DATA_W-1],
                               data_result[DATA_W-1]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= ovf_sticky | overflow;
    end
  end

endmodule

// File: tb/tb_sub.sv
// Scoreboard bench for sub: stimulus pushes expectations, a monitor pops and compares
// whenever the stimulus side raises its sample strobe.
module tb_sub;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_result;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        overflow;
  logic        ovf_sticky;
  logic        check_req;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        chk_sticky;
    logic [31:0] res;
    logic        ovf;
    logic        sticky;
    string       tag;
  } exp_t;

  exp_t scb[$];

  sub #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .data_result   (data_result),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .overflow      (overflow),
    .ovf_sticky    (ovf_sticky)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: 33-bit sign-extended difference; overflow when the top two bits disagree.
  function automatic void model_sub(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic ovf);
    logic [32:0] wide;
    wide = {a[31], a} - {b[31], b};
    res  = wide[31:0];
    ovf  = wide[32] ^ wide[31];
  endfunction

  task automatic fire();
    check_req = 1'b1;
    #1;
    check_req = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input logic exp_ovf,
                               input string tag);
    exp_t e;
    data_operandA = a;
    data_operandB = b;
    e.chk_sticky = 1'b0;
    e.res        = exp_res;
    e.ovf        = exp_ovf;
    e.sticky     = 1'b0;
    e.tag        = tag;
    scb.push_back(e);
    #1;
    fire();
  endtask

  task automatic applyModel(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] r;
    logic        o;
    model_sub(a, b, r, o);
    applyStimulus(a, b, r, o, tag);
  endtask

  task automatic checkOutput(input logic exp_sticky, input string tag);
    exp_t e;
    e.chk_sticky = 1'b1;
    e.res        = '0;
    e.ovf        = 1'b0;
    e.sticky     = exp_sticky;
    e.tag        = tag;
    scb.push_back(e);
    fire();
  endtask

  // Monitor: one expectation consumed per strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge check_req);
      if (scb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL scoreboard_underflow: strobe with no expectation queued");
      end else begin
        e = scb.pop_front();
        if (e.chk_sticky) begin
          compared++;
          if (ovf_sticky !== e.sticky) begin
            mismatched++;
            $display("[TB] FAIL %s: ovf_sticky got %b expected %b", e.tag, ovf_sticky, e.sticky);
          end
        end else begin
          compared += 2;
          if (data_result !== e.res) begin
            mismatched++;
            $display("[TB] FAIL %s: data_result got 0x%08h expected 0x%08h (A=0x%08h B=0x%08h)",
                     e.tag, data_result, e.res, data_operandA, data_operandB);
          end
          if (overflow !== e.ovf) begin
            mismatched++;
            $display("[TB] FAIL %s: overflow got %b expected %b (A=0x%08h B=0x%08h)",
                     e.tag, overflow, e.ovf, data_operandA, data_operandB);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    check_req     = 1'b0;
    reset_n       = 1'b0;
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    #2;
    checkOutput(1'b0, "reset_state");

    // Combinational path stays live while reset holds the flag clear.
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "ovf_during_reset");
    @(posedge clock); #1;
    checkOutput(1'b0, "reset_wins_over_ovf");

    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(32'd5, 32'd5, 32'd0, 1'b0, "equal_operands");
    @(posedge clock); #1;
    checkOutput(1'b0, "first_edge_no_ovf");

    // Overflow pulse confined between edges must not be captured.
    @(negedge clock);
    applyStimulus(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, "min_minus_one");
    applyStimulus(32'd5, 32'd5, 32'd0, 1'b0, "pulse_removed");
    @(posedge clock); #1;
    checkOutput(1'b0, "pulse_not_captured");

    @(negedge clock);
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "max_minus_neg_one");
    @(posedge clock); #1;
    checkOutput(1'b1, "sticky_set");

    @(negedge clock);
    applyStimulus(32'd1, 32'd2, 32'hFFFF_FFFF, 1'b0, "one_minus_two");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      checkOutput(1'b1, "sticky_hold");
    end

    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput(1'b0, "async_reset_clear");

    applyStimulus(32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, "zero_minus_one");
    applyStimulus(32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, "min_minus_min");
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "max_minus_min");
    applyStimulus(32'd162346, 32'd24124, 32'd138222, 1'b0, "base_vector");
    reset_n = 1'b1;

    // Bit toggles on the base vector every 10/20/40 ns.
    a = 32'd162346;
    b = 32'd24124;
    for (int t = 1; t <= 8; t++) begin
      a[0] = ~a[0];
      if (t % 2 == 0) begin
        a[1] = ~a[1];
        b[0] = ~b[0];
      end
      if (t % 4 == 0) begin
        a[7] = ~a[7];
        b[7] = ~b[7];
      end
      applyModel(a, b, "toggle");
      #8;
    end

    for (int i = 0; i < 10000; i++) begin
      applyModel($urandom, $urandom, "random");
    end

    #5;
    if (scb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", scb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
